// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared state encoding, table-size helper and default golden table
package tt_sweep_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam logic [15:0] TT_RST_DEFAULT = 16'hF830;
    function automatic int tt_size(input int n);
        return 1 << n;
    endfunction
endpackage

// File: rtl/tt_step_timer.sv
// tt_step_timer: STEP_CYC-modulo hold counter with clear and last-cycle strobe
module tt_step_timer #(
    parameter int STEP_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);
    logic [3:0] cnt_q, cnt_d;
    assign last_o = cnt_q == 4'(STEP_CYC - 1);
    always_comb cnt_d = clr_i ? 4'd0 : !en_i ? cnt_q : last_o ? 4'd0 : cnt_q + 4'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: exhaustive truth-table sweep of an external DUT against a golden table
// Define TT_SWEEP_STOP_ON_ERR_EN to end the sweep on the first mismatch, holding the failing vector.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int                         N_IN     = 4,
    parameter logic [tt_size(N_IN)-1:0]   TT_RST   = TT_RST_DEFAULT,
    parameter int                         STEP_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     tt_load,
    input  logic [tt_size(N_IN)-1:0] tt_in,
    input  logic                     f_ext,
    output logic [N_IN-1:0]          x_out,
    output logic                     busy,
    output logic                     done,
    output logic [N_IN:0]            ones_cnt,
    output logic [N_IN:0]            err_cnt,
    output logic                     err_flag
);
    localparam int TT_W = tt_size(N_IN);
    state_t state_q, state_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [N_IN:0] ones_q, ones_d, err_q, err_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic idle, accept, last, sample, mism, hold, stop;
    tt_step_timer #(.STEP_CYC(STEP_CYC)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .en_i   (state_q == RUN),
        .last_o (last)
    );
    assign idle   = state_q != RUN;
    assign accept = idle && start;
    assign sample = state_q == RUN && last;
    assign mism   = f_ext != tt_q[x_q];
`ifdef TT_SWEEP_STOP_ON_ERR_EN
    assign hold = mism;
`else
    assign hold = 1'b0;
`endif
    assign stop = hold || &x_q;
    // a load coinciding with start lands before the first sample, so the sweep sees the new table
    always_comb begin
        state_d = state_q;
        if (accept) state_d = RUN;
        else if (sample && stop) state_d = DONE;
        tt_d   = idle && tt_load ? tt_in : tt_q;
        x_d    = accept ? '0 : sample && !hold ? x_q + N_IN'(1) : x_q;
        ones_d = accept ? '0 : sample ? ones_q + (N_IN+1)'(f_ext) : ones_q;
        err_d  = accept ? '0 : sample ? err_q + (N_IN+1)'(mism) : err_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            ones_q  <= '0;
            err_q   <= '0;
            tt_q    <= TT_RST;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            ones_q  <= ones_d;
            err_q   <= err_d;
            tt_q    <= tt_d;
        end
    end
    assign x_out    = x_q;
    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign ones_cnt = ones_q;
    assign err_cnt  = err_q;
    assign err_flag = done && |err_q;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: scoreboard bench; instance 0 steps every cycle against F=A(B+CD)+BC', instance 1 holds 3 cycles with f_ext=1
module tb_tt_sweep_checker;
    typedef struct {
        int ones;
        int err;
        int flag;
        int lat;
    } exp_t;
    logic clk = 0;
    logic rst_n;
    logic start[2];
    logic tt_load[2];
    logic [15:0] tt_in[2];
    logic f_ext[2];
    logic [3:0] x_out[2];
    logic busy[2], done[2], err_flag[2];
    logic [4:0] ones_cnt[2], err_cnt[2];
    exp_t exp_q[2][$];
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    function automatic logic fmodel(input logic [3:0] x);
        return (x[3] & (x[2] | (x[1] & x[0]))) | (x[2] & ~x[1]);
    endfunction
    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : gen_u
        localparam int STEP = g ? 3 : 1;
        int cyc = 0;
        logic prev_done = 0;
        exp_t e;
        tt_sweep_checker #(.N_IN(4), .TT_RST(16'hF830), .STEP_CYC(STEP)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[g]),
            .tt_load  (tt_load[g]),
            .tt_in    (tt_in[g]),
            .f_ext    (f_ext[g]),
            .x_out    (x_out[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .ones_cnt (ones_cnt[g]),
            .err_cnt  (err_cnt[g]),
            .err_flag (err_flag[g])
        );
        assign f_ext[g] = (g == 1) ? 1'b1 : fmodel(x_out[g]);
        always @(negedge clk) begin
            if (!rst_n) begin
                cyc = 0;
                prev_done = 0;
            end else begin
                if (busy[g]) begin
                    chk($sformatf("x_out_u%0d_c%0d", g, cyc), x_out[g], (cyc / STEP) % 16);
                    cyc++;
                end
                if (done[g] && !prev_done) begin
                    checks++;
                    if (exp_q[g].size() == 0) begin
                        errors++;
                        $display("FAIL done_u%0d: got unexpected done expected none", g);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("ones_u%0d", g), ones_cnt[g], e.ones);
                        chk($sformatf("err_u%0d", g), err_cnt[g], e.err);
                        chk($sformatf("err_flag_u%0d", g), err_flag[g], e.flag);
                        chk($sformatf("x_wrap_u%0d", g), x_out[g], 0);
                        chk($sformatf("latency_u%0d", g), cyc, e.lat);
                    end
                    cyc = 0;
                end
                prev_done = done[g];
            end
        end
    end
    task automatic drive(input int g, input logic st, input logic ld, input logic [15:0] tt);
        start[g] = st;
        tt_load[g] = ld;
        tt_in[g] = tt;
        @(negedge clk);
        start[g] = 0;
        tt_load[g] = 0;
    endtask
    task automatic wait_done(input int g);
        for (int i = 0; i < 200 && !done[g]; i++) @(negedge clk);
        if (!done[g]) begin
            checks++;
            errors++;
            $display("FAIL timeout_u%0d: got done=0 expected done=1 within 200 cycles", g);
        end
    endtask
    initial begin
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 0;
            tt_load[i] = 0;
            tt_in[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_x", x_out[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_ones", ones_cnt[0], 0);
        chk("rst_err", err_cnt[0], 0);
        chk("rst_flag", err_flag[0], 0);
        rst_n = 1;
        @(negedge clk);
        exp_q[0].push_back('{7, 0, 0, 16});
        drive(0, 1, 0, 16'h0);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("done_hold", done[0], 1);
        chk("ones_hold", ones_cnt[0], 7);
        exp_q[0].push_back('{7, 1, 1, 16});
        drive(0, 1, 1, 16'hF831);
        wait_done(0);
        exp_q[0].push_back('{7, 1, 1, 16});
        drive(0, 1, 0, 16'h0);
        repeat (3) @(negedge clk);
        drive(0, 1, 1, 16'hF830);
        wait_done(0);
        drive(0, 1, 0, 16'h0);
        for (int i = 0; i < 100 && x_out[0] != 4'd8; i++) @(negedge clk);
        chk("pre_abort_ones", ones_cnt[0], 2);
        chk("pre_abort_err", err_cnt[0], 1);
        #1 rst_n = 0;
        #1;
        chk("abort_x", x_out[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_ones", ones_cnt[0], 0);
        chk("abort_err", err_cnt[0], 0);
        chk("abort_done", done[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        exp_q[0].push_back('{7, 0, 0, 16});
        drive(0, 1, 0, 16'h0);
        wait_done(0);
        exp_q[1].push_back('{16, 9, 1, 48});
        drive(1, 1, 0, 16'h0);
        wait_done(1);
        repeat (2) @(negedge clk);
        chk("queue_empty_u0", exp_q[0].size(), 0);
        chk("queue_empty_u1", exp_q[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
